// File: rtl/rp_mask_apply.sv
`default_nettype none
// ============================================================================
//  Module      : rp_mask_apply
//  Description : Random-projection pruning consumer. Captures a per-chunk
//                dimension enable mask, counts the kept dimensions, then
//                streams query HV chunks through a one-deep output register,
//                zeroing pruned dimensions on the way.
//  Revision    : 1.0  initial release
// ============================================================================
module rp_mask_apply #(
    parameter  int HV_DIM          = 4096,
    parameter  int DIMS_PER_CC     = 1024,
    parameter  int SEQ_CYCLE_COUNT = 4,
    localparam int KEPT_W          = $clog2(HV_DIM + 1),
    localparam int IDX_W           = (SEQ_CYCLE_COUNT > 1) ? $clog2(SEQ_CYCLE_COUNT) : 1
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   load_start,
    input  logic                   mask_valid,
    input  logic [DIMS_PER_CC-1:0] mask_in,
    output logic                   mask_loaded,
    output logic [KEPT_W-1:0]      kept_count,
    input  logic                   hv_valid,
    output logic                   hv_ready,
    input  logic [DIMS_PER_CC-1:0] hv_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DIMS_PER_CC-1:0] out_hv,
    output logic [IDX_W-1:0]       out_chunk_idx,
    output logic                   out_last
);

    localparam int               c_PC_W     = $clog2(DIMS_PER_CC + 1);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(SEQ_CYCLE_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ARMED = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [DIMS_PER_CC-1:0]   r_mask [SEQ_CYCLE_COUNT];
    logic [KEPT_W-1:0]        r_kept_count;
    logic [IDX_W-1:0]         r_load_idx;
    logic [IDX_W-1:0]         r_q_idx;
    logic                     r_out_valid;
    logic [DIMS_PER_CC-1:0]   r_out_hv;
    logic [IDX_W-1:0]         r_out_idx;
    logic                     r_out_last;
    logic                     w_hv_ready;
    logic                     w_capture;
    logic                     w_accept;
    logic [c_PC_W-1:0]        w_popcount;

    // Number of set bits in one mask chunk.
    function automatic logic [c_PC_W-1:0] f_popcount(input logic [DIMS_PER_CC-1:0] v);
        logic [c_PC_W-1:0] s;
        s = '0;
        for (int i = 0; i < DIMS_PER_CC; i++) begin
            s = s + c_PC_W'(v[i]);
        end
        return s;
    endfunction

    assign w_popcount = f_popcount(mask_in);

    // load_start wins over a same-cycle capture or accept, so both are gated here.
    assign w_capture = (r_state == ST_LOAD) && mask_valid && !load_start;
    assign w_accept  = hv_valid && w_hv_ready;

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and the combinational query-side ready.
    always_comb begin
        w_state_nxt = r_state;
        w_hv_ready  = 1'b0;
        if (load_start) begin
            w_state_nxt = ST_LOAD;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_LOAD: begin
                    if (mask_valid && (r_load_idx == c_LAST_IDX)) begin
                        w_state_nxt = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    // One-deep register: free when empty or draining this cycle.
                    w_hv_ready = !r_out_valid || out_ready;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Mask capture, kept-dimension count and the masked output register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < SEQ_CYCLE_COUNT; i++) begin
                r_mask[i] <= '0;
            end
            r_kept_count <= '0;
            r_load_idx   <= '0;
            r_q_idx      <= '0;
            r_out_valid  <= 1'b0;
            r_out_hv     <= '0;
            r_out_idx    <= '0;
            r_out_last   <= 1'b0;
        end else if (load_start) begin
            for (int i = 0; i < SEQ_CYCLE_COUNT; i++) begin
                r_mask[i] <= '0;
            end
            r_kept_count <= '0;
            r_load_idx   <= '0;
            r_q_idx      <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_mask[r_load_idx] <= mask_in;
                r_kept_count       <= r_kept_count + KEPT_W'(w_popcount);
                r_load_idx         <= (r_load_idx == c_LAST_IDX) ? '0 : r_load_idx + 1'b1;
            end
            if (w_accept) begin
                r_out_hv    <= hv_in & r_mask[r_q_idx];
                r_out_idx   <= r_q_idx;
                r_out_last  <= (r_q_idx == c_LAST_IDX);
                r_out_valid <= 1'b1;
                r_q_idx     <= (r_q_idx == c_LAST_IDX) ? '0 : r_q_idx + 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign mask_loaded   = (r_state == ST_ARMED);
    assign kept_count    = r_kept_count;
    assign hv_ready      = w_hv_ready;
    assign out_valid     = r_out_valid;
    assign out_hv        = r_out_hv;
    assign out_chunk_idx = r_out_idx;
    assign out_last      = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_rp_mask_apply.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rp_mask_apply
//  Description : Self-checking bench for rp_mask_apply. Directed scenarios
//                plus a randomized phase, checked every cycle against a
//                queue-based reference model of the mask/stream behaviour.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rp_mask_apply;

    localparam int HV_DIM = 4096;
    localparam int DW     = 1024;
    localparam int SEQ    = 4;
    localparam int KW     = 13;
    localparam int IW     = 2;

    logic          clk = 1'b0;
    logic          nrst;
    logic          load_start;
    logic          mask_valid;
    logic [DW-1:0] mask_in;
    logic          mask_loaded;
    logic [KW-1:0] kept_count;
    logic          hv_valid;
    logic          hv_ready;
    logic [DW-1:0] hv_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_hv;
    logic [IW-1:0] out_chunk_idx;
    logic          out_last;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: abstract mode, captured mask chunks, expected outputs.
    int            m_mode;       // 0 idle, 1 loading, 2 armed
    int            m_captured;
    logic [DW-1:0] m_mask [SEQ];
    int            m_qi;
    logic [DW-1:0] q_hv [$];
    int            q_idx [$];

    rp_mask_apply #(
        .HV_DIM          (HV_DIM),
        .DIMS_PER_CC     (DW),
        .SEQ_CYCLE_COUNT (SEQ)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .load_start    (load_start),
        .mask_valid    (mask_valid),
        .mask_in       (mask_in),
        .mask_loaded   (mask_loaded),
        .kept_count    (kept_count),
        .hv_valid      (hv_valid),
        .hv_ready      (hv_ready),
        .hv_in         (hv_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_hv        (out_hv),
        .out_chunk_idx (out_chunk_idx),
        .out_last      (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_hv(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        int w;
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            w = 0;
            for (int i = DW / 64 - 1; i >= 0; i--) begin
                if (obs[i*64 +: 64] !== exp[i*64 +: 64]) w = i;
            end
            $error("FAIL %s word%0d observed=%h expected=%h", tag, w, obs[w*64 +: 64], exp[w*64 +: 64]);
        end
    endtask

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int model_kept();
        int s = 0;
        for (int i = 0; i < SEQ; i++) s += $countones(m_mask[i]);
        return s;
    endfunction

    task automatic model_clear();
        m_captured = 0;
        m_qi       = 0;
        for (int i = 0; i < SEQ; i++) m_mask[i] = '0;
        q_hv.delete();
        q_idx.delete();
    endtask

    task automatic drive(input logic ls, input logic mv, input logic [DW-1:0] mi,
                         input logic hvv, input logic [DW-1:0] hvi, input logic ordy);
        load_start = ls;
        mask_valid = mv;
        mask_in    = mi;
        hv_valid   = hvv;
        hv_in      = hvi;
        out_ready  = ordy;
    endtask

    // One clock: compare DUT against the model mid-cycle, then advance the model.
    task automatic cycle();
        logic exp_valid;
        logic exp_ready;
        @(negedge clk);
        exp_valid = (q_hv.size() != 0);
        chk("out_valid", 64'(out_valid), 64'(exp_valid));
        if (exp_valid) begin
            chk_hv("out_hv", out_hv, q_hv[0]);
            chk("out_chunk_idx", 64'(out_chunk_idx), 64'(q_idx[0]));
            chk("out_last", 64'(out_last), 64'(q_idx[0] == SEQ - 1));
        end
        chk("mask_loaded", 64'(mask_loaded), 64'(m_mode == 2));
        chk("kept_count", 64'(kept_count), 64'(model_kept()));
        exp_ready = (m_mode == 2) && (!exp_valid || out_ready) && !load_start;
        chk("hv_ready", 64'(hv_ready), 64'(exp_ready));
        if (load_start) begin
            model_clear();
            m_mode = 1;
        end else begin
            if (exp_valid && out_ready) begin
                void'(q_hv.pop_front());
                void'(q_idx.pop_front());
            end
            if (hv_valid && exp_ready) begin
                q_hv.push_back(hv_in & m_mask[m_qi]);
                q_idx.push_back(m_qi);
                m_qi = (m_qi + 1) % SEQ;
            end
            if (m_mode == 1 && mask_valid) begin
                m_mask[m_captured] = mask_in;
                m_captured++;
                if (m_captured == SEQ) m_mode = 2;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse, checked while nrst is still low.
    task automatic do_reset();
        nrst = 1'b0;
        #2;
        chk("rst mask_loaded", 64'(mask_loaded), 64'd0);
        chk("rst kept_count", 64'(kept_count), 64'd0);
        chk("rst hv_ready", 64'(hv_ready), 64'd0);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_last", 64'(out_last), 64'd0);
        chk("rst out_chunk_idx", 64'(out_chunk_idx), 64'd0);
        chk_hv("rst out_hv", out_hv, '0);
        model_clear();
        m_mode = 0;
        @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] ones;
        logic [DW-1:0] alt;
        logic [DW-1:0] pat [SEQ];
        ones = '1;
        alt  = {(DW / 4){4'hA}};
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        nrst = 1'b1;
        #1;
        do_reset();

        // IDLE ignores mask_valid and holds hv_ready low.
        drive(1'b0, 1'b1, ones, 1'b1, ones, 1'b1);
        cycle();

        // Reset in the middle of a load.
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1); cycle();
        drive(1'b0, 1'b1, rand_vec(), 1'b0, '0, 1'b1); cycle();
        drive(1'b0, 1'b1, rand_vec(), 1'b0, '0, 1'b1); cycle();
        do_reset();

        // Full all-ones load.
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1); cycle();
        for (int i = 0; i < SEQ; i++) begin
            drive(1'b0, 1'b1, ones, 1'b0, '0, 1'b1); cycle();
        end
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1); cycle();
        chk("all-ones mask_loaded", 64'(mask_loaded), 64'd1);
        chk("all-ones kept_count", 64'(kept_count), 64'd4096);

        // Patterned mask: ones, zeros, 0xAAAA.., zeros.
        pat[0] = ones; pat[1] = '0; pat[2] = alt; pat[3] = '0;
        drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1); cycle();
        for (int i = 0; i < SEQ; i++) begin
            drive(1'b0, 1'b1, pat[i], 1'b0, '0, 1'b1); cycle();
        end
        chk("pattern kept_count", 64'(kept_count), 64'd1536);
        for (int i = 0; i < SEQ; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1, ones, 1'b1); cycle();
        end
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1); cycle();

        // Backpressure: three stalled cycles, then release with random chunks.
        drive(1'b0, 1'b0, '0, 1'b1, rand_vec(), 1'b1); cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1, rand_vec(), 1'b0); cycle();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1, rand_vec(), 1'b1); cycle();
        end
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1); cycle();

        // Six-chunk stream to cover index wrap.
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1, rand_vec(), 1'b1); cycle();
        end
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1); cycle();

        // load_start while an output is stalled; same-cycle mask chunk is dropped.
        drive(1'b0, 1'b0, '0, 1'b1, rand_vec(), 1'b0); cycle();
        drive(1'b1, 1'b1, ones, 1'b1, rand_vec(), 1'b0); cycle();
        chk("ls out_valid", 64'(out_valid), 64'd0);
        chk("ls kept_count", 64'(kept_count), 64'd0);

        // Load with gaps: captures on cycles 0, 3, 4 and 9.
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, (c == 0 || c == 3 || c == 4 || c == 9), rand_vec(), 1'b0, '0, 1'b1);
            cycle();
        end
        drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1); cycle();
        // mask_valid pulses while armed must not disturb the mask or count.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, rand_vec(), 1'b1, rand_vec(), 1'b1); cycle();
        end

        // Randomized traffic, including occasional reloads and a mid-run reset.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1), rand_vec(),
                  ($urandom_range(0, 3) != 0), rand_vec(), ($urandom_range(0, 3) != 0));
            cycle();
            if (i == 200) do_reset();
            if (i == 201) begin
                drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1); cycle();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
